// File: rtl/fifo_drain_rr.sv
// fifo_drain_rr: round-robin consumer for the four egress FIFOs (ports 4..7) of the
// 4x4 routing switch. Issues one pop per cycle at most, captures the word the
// following cycle and serialises it onto a single tagged output stream, keeping
// per-port saturating word counts and a sticky wrong-destination flag.
module fifo_drain_rr #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              enable,
  input  logic              empty4,
  input  logic              empty5,
  input  logic              empty6,
  input  logic              empty7,
  input  logic [DATA_W-1:0] data4,
  input  logic [DATA_W-1:0] data5,
  input  logic [DATA_W-1:0] data6,
  input  logic [DATA_W-1:0] data7,
  output logic              pop4,
  output logic              pop5,
  output logic              pop6,
  output logic              pop7,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [1:0]        port_out,
  output logic [CNT_W-1:0]  cnt4,
  output logic [CNT_W-1:0]  cnt5,
  output logic [CNT_W-1:0]  cnt6,
  output logic [CNT_W-1:0]  cnt7,
  output logic              err_dest
);

  typedef enum logic {
    StIdle,
    StCap
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e            r_state;
  state_e            w_state_nxt;
  logic [1:0]        r_ptr;
  logic [1:0]        r_cap_idx;

  logic [3:0]        w_empty;
  logic [3:0]        w_cand;
  logic              w_grant_vld;
  logic [1:0]        w_grant_idx;
  logic [3:0]        w_pop;
  logic [DATA_W-1:0] w_cap_data;
  logic [1:0]        w_cap_dest;
  logic              w_can_pop;

  logic [DATA_W-1:0] r_data_out;
  logic [1:0]        r_port_out;
  logic              r_valid_out;
  logic [CNT_W-1:0]  r_cnt [4];
  logic              r_err_dest;

  assign w_empty   = {empty7, empty6, empty5, empty4};
  assign w_can_pop = enable && !reset && !init;

  // Round-robin grant: first non-empty port at or after the pointer, skipping the
  // port popped last cycle because its empty flag has not caught up yet.
  always_comb begin
    w_cand = ~w_empty;
    if (r_state == StCap) begin
      w_cand[r_cap_idx] = 1'b0;
    end
    w_grant_vld = 1'b0;
    w_grant_idx = r_ptr;
    // Descending scan so the smallest offset from the pointer wins.
    for (int k = 3; k >= 0; k--) begin
      if (w_cand[r_ptr + 2'(k)]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = r_ptr + 2'(k);
      end
    end
    if (!w_can_pop) begin
      w_grant_vld = 1'b0;
    end
  end

  // Decode the grant into the one-cycle pop strobes.
  always_comb begin
    w_pop = 4'b0000;
    if (w_grant_vld) begin
      w_pop = 4'b0001 << w_grant_idx;
    end
  end

  assign pop4 = w_pop[0];
  assign pop5 = w_pop[1];
  assign pop6 = w_pop[2];
  assign pop7 = w_pop[3];

  // Next state: a capture is pending exactly when a pop was issued this cycle.
  always_comb begin
    w_state_nxt = StIdle;
    if (w_grant_vld) begin
      w_state_nxt = StCap;
    end
  end

  // Select the read data of the port popped last cycle.
  always_comb begin
    w_cap_data = data4;
    unique case (r_cap_idx)
      2'd0:    w_cap_data = data4;
      2'd1:    w_cap_data = data5;
      2'd2:    w_cap_data = data6;
      2'd3:    w_cap_data = data7;
      default: w_cap_data = data4;
    endcase
    w_cap_dest = w_cap_data[DATA_W-1 -: 2];
  end

  // State, rr pointer and pending-capture index; init drops any pop in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_ptr     <= 2'd0;
      r_cap_idx <= 2'd0;
    end else if (init) begin
      r_state   <= StIdle;
      r_ptr     <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_vld) begin
        r_cap_idx <= w_grant_idx;
        r_ptr     <= w_grant_idx + 2'd1;
      end
    end
  end

  // Output capture register; init keeps the last word but kills valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out  <= '0;
      r_port_out  <= 2'd0;
      r_valid_out <= 1'b0;
    end else if (init) begin
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= (r_state == StCap);
      if (r_state == StCap) begin
        r_data_out <= w_cap_data;
        r_port_out <= r_cap_idx;
      end
    end
  end

  // Per-port saturating word counters.
  always_ff @(posedge clk) begin
    if (reset || init) begin
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (r_state == StCap && r_cnt[r_cap_idx] != CntMax) begin
      r_cnt[r_cap_idx] <= r_cnt[r_cap_idx] + 1'b1;
    end
  end

  // Sticky flag for a word whose destination field disagrees with its source port.
  always_ff @(posedge clk) begin
    if (reset || init) begin
      r_err_dest <= 1'b0;
    end else if (r_state == StCap && w_cap_dest != r_cap_idx) begin
      r_err_dest <= 1'b1;
    end
  end

  assign data_out  = r_data_out;
  assign port_out  = r_port_out;
  assign valid_out = r_valid_out;
  assign cnt4      = r_cnt[0];
  assign cnt5      = r_cnt[1];
  assign cnt6      = r_cnt[2];
  assign cnt7      = r_cnt[3];
  assign err_dest  = r_err_dest;

endmodule

// File: tb/tb_fifo_drain_rr.sv
// Bench for fifo_drain_rr: behavioural FIFOs with a lagging empty flag feed the
// DUT; a scoreboard queue holds the expected {port, word} stream and a negedge
// monitor checks every valid_out beat and the legality of every pop.
module tb_fifo_drain_rr;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] emp = 4'b1111;
  logic [9:0] dat [4];
  logic       pop4, pop5, pop6, pop7;
  logic [9:0] data_out;
  logic       valid_out;
  logic [1:0] port_out;
  logic [7:0] cnt4, cnt5, cnt6, cnt7;
  logic       err_dest;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [9:0]  fq [4][$];
  logic [11:0] exp_q [$];
  int          pop_port [$];
  int          pop_cyc [$];
  int          val_cyc [$];
  logic [3:0]  p_neg = 4'b0000;
  logic [3:0]  p_prev = 4'b0000;

  fifo_drain_rr #(
    .DATA_W(10),
    .CNT_W (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .init     (init),
    .enable   (enable),
    .empty4   (emp[0]),
    .empty5   (emp[1]),
    .empty6   (emp[2]),
    .empty7   (emp[3]),
    .data4    (dat[0]),
    .data5    (dat[1]),
    .data6    (dat[2]),
    .data7    (dat[3]),
    .pop4     (pop4),
    .pop5     (pop5),
    .pop6     (pop6),
    .pop7     (pop7),
    .data_out (data_out),
    .valid_out(valid_out),
    .port_out (port_out),
    .cnt4     (cnt4),
    .cnt5     (cnt5),
    .cnt6     (cnt6),
    .cnt7     (cnt7),
    .err_dest (err_dest)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // FIFO model: data registered on pop; empty reflects occupancy one cycle late.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      emp[i] <= (fq[i].size() == 0);
      if (p_neg[i]) begin
        checks++;
        if (fq[i].size() == 0) begin
          errors++;
          $display("FAIL overpop: port %0d popped while holding 0 words", i + 4);
        end else begin
          dat[i] <= fq[i].pop_front();
        end
      end
    end
  end

  // Monitor: pop legality and scoreboard comparison of each output beat.
  always @(negedge clk) begin
    p_neg = {pop7, pop6, pop5, pop4};
    if (p_neg != 4'b0000) begin
      checks++;
      if (!$onehot(p_neg) || reset || init || !enable || (p_neg & p_prev) != 4'b0000) begin
        errors++;
        $display("FAIL pop_legal: pops=%b prev=%b reset=%b init=%b enable=%b", p_neg, p_prev,
                 reset, init, enable);
      end
      for (int i = 0; i < 4; i++) begin
        if (p_neg[i]) begin
          pop_port.push_back(i);
          pop_cyc.push_back(cyc);
        end
      end
    end
    p_prev = p_neg;
    if (valid_out) begin
      logic [11:0] e;
      checks++;
      val_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: port=%0d data=%h, required no output", port_out,
                 data_out);
      end else begin
        e = exp_q.pop_front();
        if ({port_out, data_out} !== e) begin
          errors++;
          $display("FAIL out_word: port=%0d data=%h, required port=%0d data=%h", port_out,
                   data_out, e[11:10], e[9:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int p, input logic [9:0] d, input bit expect_out);
    fq[p].push_back(d);
    if (expect_out) exp_q.push_back({2'(p), d});
  endtask

  task automatic clear_logs();
    pop_port.delete();
    pop_cyc.delete();
    val_cyc.delete();
  endtask

  task automatic pulse_init();
    init = 1'b1;
    step(1);
    init = 1'b0;
  endtask

  // Wait until all queued words have drained and been output, then let it settle.
  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || fq[0].size() != 0 || fq[1].size() != 0 ||
            fq[2].size() != 0 || fq[3].size() != 0) && n < budget) begin
      step(1);
      n++;
    end
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: %0d words still expected after %0d cycles", name,
               exp_q.size(), budget);
      exp_q.delete();
    end
    step(4);
  endtask

  initial begin
    dat[0] = '0; dat[1] = '0; dat[2] = '0; dat[3] = '0;
    // 1: reset held with every FIFO non-empty
    enable = 1'b1;
    push(0, 10'h0FF, 1'b1);
    push(1, 10'h1EE, 1'b1);
    push(2, 10'h2DD, 1'b1);
    push(3, 10'h3CC, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_pop", {28'd0, pop7, pop6, pop5, pop4}, 0);
      chk("reset_valid", valid_out, 0);
      chk("reset_cnt", {cnt7, cnt6, cnt5, cnt4}, 0);
      chk("reset_err", err_dest, 0);
    end
    @(posedge clk);
    #1;
    clear_logs();

    // 2: one word per FIFO, drained 4,5,6,7 on consecutive cycles
    reset = 1'b0;
    wait_drain("t2", 40);
    chk("t2_npops", pop_port.size(), 4);
    if (pop_port.size() == 4 && val_cyc.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t2_pop_order", pop_port[i], i);
      for (int i = 1; i < 4; i++) begin
        chk("t2_pop_consec", pop_cyc[i] - pop_cyc[i-1], 1);
        chk("t2_valid_consec", val_cyc[i] - val_cyc[i-1], 1);
      end
      chk("t2_latency", val_cyc[0] - pop_cyc[0], 2);
    end
    chk("t2_cnt", {cnt7, cnt6, cnt5, cnt4}, 32'h01010101);
    chk("t2_err", err_dest, 0);

    // 3: single non-empty FIFO5 with three words
    pulse_init();
    clear_logs();
    push(1, 10'h101, 1'b1);
    push(1, 10'h102, 1'b1);
    push(1, 10'h103, 1'b1);
    wait_drain("t3", 40);
    chk("t3_npops", pop_port.size(), 3);
    if (pop_port.size() == 3) begin
      for (int i = 1; i < 3; i++) chk("t3_pop_gap_ok", (pop_cyc[i] - pop_cyc[i-1]) >= 2, 1);
    end
    chk("t3_cnt5", cnt5, 3);

    // 4: misrouted word on FIFO6 sets the sticky error, init clears it
    push(2, 10'h0AA, 1'b1);
    wait_drain("t4", 40);
    chk("t4_err_set", err_dest, 1);
    step(5);
    chk("t4_err_sticky", err_dest, 1);
    chk("t4_cnt6", cnt6, 1);
    pulse_init();
    @(negedge clk);
    chk("t4_err_init", err_dest, 0);
    chk("t4_cnt_init", {cnt7, cnt6, cnt5, cnt4}, 0);
    step(1);

    // 5: 256 words through FIFO4 saturate its counter
    for (int i = 0; i < 256; i++) push(0, {2'b00, 8'(i)}, 1'b1);
    wait_drain("t5", 2000);
    chk("t5_cnt4_sat", cnt4, 255);
    chk("t5_err", err_dest, 0);

    // 6a: enable drops right after a pop4; that word still comes out
    pulse_init();
    enable = 1'b0;
    push(0, 10'h033, 1'b1);
    push(1, 10'h1AB, 1'b0);
    step(3);
    clear_logs();
    enable = 1'b1;
    step(1);
    enable = 1'b0;
    step(5);
    chk("t6_npops", pop_port.size(), 1);
    if (pop_port.size() == 1) chk("t6_pop_port", pop_port[0], 0);
    chk("t6_word_out", exp_q.size(), 0);
    chk("t6_cnt4", cnt4, 1);

    // 6b: reset during a pending capture discards it and rewinds the pointer
    push(0, 10'h044, 1'b1);
    push(2, 10'h2C1, 1'b1);
    push(3, 10'h3D2, 1'b1);
    step(3);
    clear_logs();
    enable = 1'b1;
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_valid_after_reset", valid_out, 0);
    wait_drain("t6", 40);
    chk("t6_npops_b", pop_port.size(), 4);
    if (pop_port.size() == 4) begin
      chk("t6_pre_reset_pop", pop_port[0], 1);
      chk("t6_ptr_rewound", pop_port[1], 0);
    end
    chk("t6_cnt_after", {cnt7, cnt6, cnt5, cnt4}, 32'h01010001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
